// File: rtl/stride_pkg.sv
// stride_pkg: shared FSM state type and width helpers for stride_gather
// Contents:
//   state_t - IDLE / GATHER / EMIT
//   idx_w   - width of the scan index; it must hold offset plus one stride without wrapping
//   cnt_w   - width of a bit count from 0 to OUT_W
package stride_pkg;

    typedef enum logic [1:0] {IDLE, GATHER, EMIT} state_t;

    function automatic int idx_w(input int len, input int stride_w);
        return $clog2(len) + stride_w + 1;
    endfunction

    function automatic int cnt_w(input int out_w);
        return $clog2(out_w + 1);
    endfunction

endpackage

// File: rtl/stride_bit_mux.sv
// stride_bit_mux: LEN:1 bit select of the latched word, 0 for out-of-range index
// Ports:
//   data_i [LEN-1:0]  word being scanned
//   idx_i  [IW-1:0]   scan index
//   bit_o             data_i[idx_i], or 0 when idx_i >= LEN
module stride_bit_mux #(
    parameter int LEN = 16,
    parameter int IW  = 8
) (
    input  logic [LEN-1:0] data_i,
    input  logic [IW-1:0]  idx_i,
    output logic           bit_o
);

    localparam int OW = $clog2(LEN);

    assign bit_o = (idx_i < IW'(LEN)) ? data_i[idx_i[OW-1:0]] : 1'b0;

endmodule

// File: rtl/stride_gather.sv
// stride_gather: gathers bits of a word at offset + k*stride and emits them as packed words
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        input word handshake (ready only in IDLE)
//   in_data [LEN]            word to gather from
//   cfg_stride [STRIDE_W]    stride, 0 treated as 1, sampled at the handshake
//   cfg_offset [clog2(LEN)]  first bit index, sampled at the handshake
//   cfg_reverse              scan downwards (only with STRIDE_GATHER_REVERSE_EN defined)
//   out_valid/out_ready      packed word handshake
//   out_data [OUT_W]         gathered bits, first in bit 0, unfilled bits 0
//   out_count                number of valid bits in out_data
//   out_last                 word ends the current input word
// Build option: STRIDE_GATHER_REVERSE_EN adds cfg_reverse.
module stride_gather
    import stride_pkg::*;
#(
    parameter  int LEN      = 16,
    parameter  int OUT_W    = 8,
    parameter  int STRIDE_W = 3,
    localparam int OW       = $clog2(LEN),
    localparam int CW       = cnt_w(OUT_W)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LEN-1:0]      in_data,
    input  logic [STRIDE_W-1:0] cfg_stride,
    input  logic [OW-1:0]       cfg_offset,
`ifdef STRIDE_GATHER_REVERSE_EN
    input  logic                cfg_reverse,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic [CW-1:0]       out_count,
    output logic                out_last
);

    localparam int IW = idx_w(LEN, STRIDE_W);

    state_t              state_q;
    logic [LEN-1:0]      data_q;
    logic [STRIDE_W-1:0] stride_q;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [OUT_W-1:0]    acc_q, acc_d;
    logic                rev_q;
    logic                bit_w, empty_w, end_d, full_d;

`ifndef STRIDE_GATHER_REVERSE_EN
    assign rev_q = 1'b0;
`endif

    stride_bit_mux #(.LEN(LEN), .IW(IW)) u_mux (
        .data_i (data_q),
        .idx_i  (idx_q),
        .bit_o  (bit_w)
    );

    assign in_ready = (state_q == IDLE);

    // An index already past the word on entry to GATHER can only come from
    // an offset >= LEN; it yields a single empty last word.
    assign empty_w = (idx_q >= IW'(LEN));

    always_comb begin
        idx_d  = rev_q ? idx_q - IW'(stride_q) : idx_q + IW'(stride_q);
        cnt_d  = cnt_q + CW'(1);
        acc_d  = acc_q | (OUT_W'(bit_w) << cnt_q);
        end_d  = rev_q ? (idx_q < IW'(stride_q)) : (idx_d >= IW'(LEN));
        full_d = (cnt_d == CW'(OUT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            stride_q  <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
`ifdef STRIDE_GATHER_REVERSE_EN
            rev_q     <= 1'b0;
`endif
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    data_q   <= in_data;
                    stride_q <= (cfg_stride == '0) ? STRIDE_W'(1) : cfg_stride;
                    idx_q    <= IW'(cfg_offset);
                    cnt_q    <= '0;
                    acc_q    <= '0;
`ifdef STRIDE_GATHER_REVERSE_EN
                    rev_q    <= cfg_reverse;
`endif
                    state_q  <= GATHER;
                end
                GATHER: if (empty_w) begin
                    out_valid <= 1'b1;
                    out_data  <= '0;
                    out_count <= '0;
                    out_last  <= 1'b1;
                    state_q   <= EMIT;
                end else begin
                    idx_q <= idx_d;
                    cnt_q <= cnt_d;
                    acc_q <= acc_d;
                    // End of scan wins over a full word, so a word that fills
                    // on the final bit is the last one.
                    if (end_d || full_d) begin
                        out_valid <= 1'b1;
                        out_data  <= acc_d;
                        out_count <= cnt_d;
                        out_last  <= end_d;
                        state_q   <= EMIT;
                    end
                end
                EMIT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (out_last) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= GATHER;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stride_gather.sv
// tb_stride_gather: directed self-checking bench for stride_gather
module tb_stride_gather;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last;
    logic [15:0] in_data = '0;
    logic [2:0]  cfg_stride = '0;
    logic [3:0]  cfg_offset = '0;
    logic        cfg_reverse = 1'b0;
    logic [7:0]  out_data;
    logic [3:0]  out_count;

    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_last;
    logic [11:0] b_in_data = '0;
    logic [2:0]  b_cfg_stride = '0;
    logic [3:0]  b_cfg_offset = '0;
    logic        b_cfg_reverse = 1'b0;
    logic [7:0]  b_out_data;
    logic [3:0]  b_out_count;

    int total = 0;
    int bad = 0;
    int n;

    always #5 clk = ~clk;

    stride_gather dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .cfg_stride(cfg_stride), .cfg_offset(cfg_offset),
`ifdef STRIDE_GATHER_REVERSE_EN
        .cfg_reverse(cfg_reverse),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_last(out_last)
    );

    // Non-power-of-two LEN so an offset >= LEN is representable.
    stride_gather #(.LEN(12), .OUT_W(8), .STRIDE_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .cfg_stride(b_cfg_stride), .cfg_offset(b_cfg_offset),
`ifdef STRIDE_GATHER_REVERSE_EN
        .cfg_reverse(b_cfg_reverse),
`endif
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_count(b_out_count), .out_last(b_out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [2:0] s, input logic [3:0] o, input logic r);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; cfg_stride = s; cfg_offset = o; cfg_reverse = r;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk);
            #1 cycles++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic word(input string tag, input logic [7:0] d, input logic [3:0] c, input logic l, input int lat);
        wait_out(n);
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_count"}, out_count, c);
        chk({tag, "_last"}, out_last, l);
        take();
    endtask

    initial begin
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_count", out_count, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;

        send(16'hAAAA, 3'd2, 4'd1, 1'b0);
        chk("busy_ready", in_ready, 0);
        word("odd", 8'hFF, 4'd8, 1'b1, 8);
        chk("idle_ready", in_ready, 1);

        send(16'hAAAA, 3'd2, 4'd0, 1'b0);
        word("even", 8'h00, 4'd8, 1'b1, 8);

        send(16'h1234, 3'd1, 4'd0, 1'b0);
        wait_out(n);
        chk("lo_lat", n, 8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, 8'h34);
            chk("hold_count", out_count, 8);
            chk("hold_last", out_last, 0);
        end
        take();
        chk("resume_valid", out_valid, 0);
        word("hi", 8'h12, 4'd8, 1'b1, 8);
        chk("after_ready", in_ready, 1);

        send(16'hFFFF, 3'd5, 4'd2, 1'b0);
        word("s5", 8'h07, 4'd3, 1'b1, 3);
        send(16'hFFFF, 3'd0, 4'd14, 1'b0);
        word("s0", 8'h03, 4'd2, 1'b1, 2);

        @(negedge clk);
        b_in_valid = 1'b1; b_in_data = 12'hFFF; b_cfg_stride = 3'd1; b_cfg_offset = 4'd13;
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        chk("oob_early", b_out_valid, 0);
        @(posedge clk);
        #1;
        chk("oob_valid", b_out_valid, 1);
        chk("oob_data", b_out_data, 0);
        chk("oob_count", b_out_count, 0);
        chk("oob_last", b_out_last, 1);
        @(negedge clk) b_out_ready = 1'b1;
        @(posedge clk);
        #1 b_out_ready = 1'b0;
        chk("oob_ready", b_in_ready, 1);

        send(16'h1234, 3'd1, 4'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_data", out_data, 0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("mid_ready", in_ready, 1);
        send(16'hAAAA, 3'd2, 4'd1, 1'b0);
        word("fresh", 8'hFF, 4'd8, 1'b1, 8);

`ifdef STRIDE_GATHER_REVERSE_EN
        send(16'h0208, 3'd3, 4'd9, 1'b1);
        word("rev", 8'h05, 4'd4, 1'b1, 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
